seq_mag_cmp: RTL

Parametrised, iterative magnitude comparator. It compares DIGIT bits per cycle, MSB-first, using the same AB/BA cascade principle as the combinational chain, and supports both signed and unsigned modes. It serves multi-cycle compare consumers in the core (SLT/SLTU, BLT/BGE/BLTU/BGEU in the low-area configuration). Operands arrive and results leave over valid/ready handshakes, with a synchronous flush from the pipeline.

---
 rtl/cmp_pkg.sv | 27 ++
 rtl/cmp_digit.sv | 43 ++++
 rtl/seq_mag_cmp.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types and helpers for the iterative magnitude comparator.
//   cmp_state_t  : controller states (IDLE, RUN, DONE)
//   cmp_result_t : one-hot compare result {lt, eq, gt}
//   num_digits() : number of DIGIT-wide slices in a WIDTH-bit operand
// -----------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_result_t;

    // WIDTH must be a whole multiple of DIGIT.
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// -----------------------------------------------------------------------------
// cmp_digit
// Combinational DIGIT-bit magnitude cascade, most significant bit first.
//   a_d, b_d : DIGIT-bit slices of A and B
//   abi, bai : incoming flags (A already known greater / B already known greater)
//   ab, ba   : outgoing flags after this slice
// A flag, once set by a more significant bit, is never cleared or overridden
// by a less significant bit.
// -----------------------------------------------------------------------------
module cmp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             abi,
    input  logic             bai,
    output logic             ab,
    output logic             ba
);

    // Stage gi handles bit DIGIT-1-gi; chain index 0 is the cascade input.
    logic [DIGIT:0] ab_c;
    logic [DIGIT:0] ba_c;

    assign ab_c[0] = abi;
    assign ba_c[0] = bai;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_stage
            logic a_bit;
            logic b_bit;
            assign a_bit = a_d[DIGIT-1-gi];
            assign b_bit = b_d[DIGIT-1-gi];
            // Only decide at this bit if no earlier bit has decided yet.
            assign ab_c[gi+1] = ab_c[gi] | (~ba_c[gi] &  a_bit & ~b_bit);
            assign ba_c[gi+1] = ba_c[gi] | (~ab_c[gi] & ~a_bit &  b_bit);
        end
    endgenerate

    assign ab = ab_c[DIGIT];
    assign ba = ba_c[DIGIT];

endmodule

// File: rtl/seq_mag_cmp.sv
// -----------------------------------------------------------------------------
// seq_mag_cmp
// Iterative magnitude comparator: DIGIT bits per cycle, MSB first, signed or
// unsigned. Signed compares are turned into unsigned ones by inverting the
// operand MSBs at capture time (offset binary).
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   flush          : synchronous abort, beats in_valid and out_ready
//   in_valid/ready : operand handshake (a, b, is_signed sampled on accept)
//   out_valid/ready: result handshake (lt, eq, gt held until consumed)
//   busy           : controller not in IDLE
//
// Build option: define SEQ_MAG_CMP_EARLY_EXIT_EN to finish as soon as the
// first differing digit is seen. Without it latency is always N cycles.
// Results are identical in both builds.
// -----------------------------------------------------------------------------
module seq_mag_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             busy
);

    localparam int N     = num_digits(WIDTH, DIGIT);
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    cmp_state_t       state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic             ab_reg;
    logic             ba_reg;
    logic [CNT_W-1:0] cnt_reg;
    cmp_result_t      res_reg;
    logic             out_valid_reg;
    logic             in_ready_reg;

    // Operands as captured: MSB inverted for signed compares.
    logic [WIDTH-1:0] a_cap;
    logic [WIDTH-1:0] b_cap;

    always_comb begin
        a_cap = a;
        b_cap = b;
        a_cap[WIDTH-1] = a[WIDTH-1] ^ is_signed;
        b_cap[WIDTH-1] = b[WIDTH-1] ^ is_signed;
    end

    // Cascade on the current top digit.
    logic ab_next;
    logic ba_next;

    cmp_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d (a_sh_reg[WIDTH-1 -: DIGIT]),
        .b_d (b_sh_reg[WIDTH-1 -: DIGIT]),
        .abi (ab_reg),
        .bai (ba_reg),
        .ab  (ab_next),
        .ba  (ba_next)
    );

    logic run_last;

`ifdef SEQ_MAG_CMP_EARLY_EXIT_EN
    // Any decided flag means the remaining digits cannot change the answer.
    assign run_last = (cnt_reg == LAST_CNT) || ab_next || ba_next;
`else
    assign run_last = (cnt_reg == LAST_CNT);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            ab_reg        <= 1'b0;
            ba_reg        <= 1'b0;
            cnt_reg       <= '0;
            res_reg       <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
        end else if (flush) begin
            state_reg     <= IDLE;
            res_reg       <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    // in_ready_reg gates acceptance so nothing is taken in the
                    // first cycle after reset, before in_ready is advertised.
                    if (in_valid && in_ready_reg) begin
                        a_sh_reg     <= a_cap;
                        b_sh_reg     <= b_cap;
                        ab_reg       <= 1'b0;
                        ba_reg       <= 1'b0;
                        cnt_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh_reg <= a_sh_reg << DIGIT;
                    b_sh_reg <= b_sh_reg << DIGIT;
                    ab_reg   <= ab_next;
                    ba_reg   <= ba_next;
                    cnt_reg  <= cnt_reg + CNT_W'(1);
                    if (run_last) begin
                        res_reg.gt    <= ab_next;
                        res_reg.lt    <= ba_next;
                        res_reg.eq    <= ~ab_next & ~ba_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    // No bypass to a new accept: IDLE is always visited.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign lt        = res_reg.lt;
    assign eq        = res_reg.eq;
    assign gt        = res_reg.gt;
    assign busy      = (state_reg != IDLE);

endmodule
